// File: rtl/axis_fifo_buffer.sv
// -----------------------------------------------------------------------------
// axis_fifo_buffer
//
// DEPTH-entry AXI-Stream FIFO. Accepts and delivers one beat per clock with
// simultaneous push and pop, and reports its fill level. With FRAME_MODE=1 the
// head beat is withheld until a complete frame (tlast) is stored, except when
// the FIFO fills without any tlast, in which case it drains in cut-through so
// the upstream cannot deadlock.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   s_tdata/s_tlast/s_tuser input beat, stored as one entry
//   s_tvalid / s_tready     input handshake; s_tready = !full (registered state)
//   m_tdata/m_tlast/m_tuser head-of-queue beat (zero while empty)
//   m_tvalid / m_tready     output handshake
//   level                   entries stored, 0..DEPTH
//   full / empty            level == DEPTH / level == 0
// -----------------------------------------------------------------------------
module axis_fifo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int FRAME_MODE = 0,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    input  logic [USER_WIDTH-1:0] s_tuser,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser,
    input  logic                  m_tready,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    typedef struct packed {
        logic [USER_WIDTH-1:0] user;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t          mem [DEPTH];
    beat_t          head;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  level_q, level_d;
    logic [LW-1:0]  frame_cnt_q, frame_cnt_d;
    logic           escape_q, escape_d;
    logic           push, pop;
    logic           push_last, pop_last;
    logic           frame_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Status comes from registered level only, so s_tready has no path
    // from m_tready: a pop while full does not open the input that cycle.
    assign full     = (level_q == LEVEL_MAX);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign s_tready = !full;

    assign push      = s_tvalid & s_tready;
    assign pop       = m_tvalid & m_tready;
    assign head      = mem[rd_ptr_q];
    assign push_last = push & s_tlast;
    assign pop_last  = pop & head.last;

    // Head beat is read from storage at rd_ptr; a write can never hit that
    // entry while it is presented because writes are blocked when full.
    // Forcing zero while empty keeps the unreset storage off the outputs.
    assign m_tdata  = empty ? '0 : head.data;
    assign m_tlast  = empty ? 1'b0 : head.last;
    assign m_tuser  = empty ? '0 : head.user;
    assign m_tvalid = !empty & frame_ok;

    // In frame mode the head is released when a whole frame is stored, when
    // full (no room left for the tlast), or while draining a frame that
    // escaped that way. escape_q keeps the drain going after the first pop
    // drops the FIFO below full, until the frame's tlast leaves or it empties.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        frame_ok = 1'b1;
        if (FRAME_MODE != 0) begin
            frame_ok = (frame_cnt_q != '0) | full | escape_q;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        frame_cnt_d = frame_cnt_q;
        case ({push_last, pop_last})
            2'b10:   frame_cnt_d = frame_cnt_q + LW'(1);
            2'b01:   frame_cnt_d = frame_cnt_q - LW'(1);
            default: frame_cnt_d = frame_cnt_q;
        endcase

        escape_d = escape_q;
        if (level_d == '0 || pop_last) begin
            escape_d = 1'b0;
        end else if (full && frame_cnt_q == '0) begin
            escape_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            escape_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            escape_q    <= escape_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by the
    // pointers and level, and stale entries are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{user: s_tuser, last: s_tlast, data: s_tdata};
        end
    end

endmodule
